// File: rtl/mole_scheduler_pkg.sv
// Shared types for the whack-a-mole scheduler: FSM state encoding, difficulty codes, hole count.
package mole_pkg;
  localparam int NUM_HOLES = 8;

  localparam logic [1:0] DIFF_EASY = 2'b00;
  localparam logic [1:0] DIFF_MED  = 2'b01;
  localparam logic [1:0] DIFF_HARD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_PICK  = 3'd2,
    ST_PROBE = 3'd3,
    ST_SPAWN = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/mole_scheduler_if.sv
// Game-side signal bundle of the mole scheduler; slave = scheduler, master = game/timer side.
interface mole_scheduler_if;
  import mole_pkg::*;

  // No valid/ready pairs: spawn/moletime and molehit are valid-only single-cycle
  // pulses the receiver must accept unconditionally; whack is a one-cycle pulse per hole.
  logic                 start;
  logic [1:0]           difficulty;
  logic [7:0]           rnd;
  logic [NUM_HOLES-1:0] mole_up;
  logic [NUM_HOLES-1:0] whack;
  logic [NUM_HOLES-1:0] spawn;
  logic [2:0]           moletime;
  logic [NUM_HOLES-1:0] molehit;
  logic [7:0]           score;
  logic [3:0]           misses;
  logic                 game_over;
  logic                 busy;
  state_e               fsm_state;

  modport slave (
    input  start, difficulty, rnd, mole_up, whack,
    output spawn, moletime, molehit, score, misses, game_over, busy, fsm_state
  );

  modport master (
    output start, difficulty, rnd, mole_up, whack,
    input  spawn, moletime, molehit, score, misses, game_over, busy, fsm_state
  );
endinterface

// File: rtl/mole_hit_tracker.sv
// Hit/miss detection, molehit pulses and score/miss counters.
// Optional whiff penalty enabled by MOLE_SCHED_WHIFF_PENALTY_EN.
module mole_hit_tracker
  import mole_pkg::*;
#(
  parameter int MAX_MISSES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 active,
  input  logic [NUM_HOLES-1:0] mole_up,
  input  logic [NUM_HOLES-1:0] whack,
  input  logic [NUM_HOLES-1:0] spawn,
  output logic [NUM_HOLES-1:0] molehit,
  output logic [7:0]           score,
  output logic [3:0]           misses
);
  localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISSES);

  logic [NUM_HOLES-1:0] up_q, hit_seen, hits, missed;
  logic [8:0]           score_sum;
  logic [7:0]           score_next;
  logic [4:0]           miss_sum;
`ifdef MOLE_SCHED_WHIFF_PENALTY_EN
  logic [NUM_HOLES-1:0] whiffs;
  logic [3:0]           whiff_n;
`endif

  always_comb begin
    // A hole being spawned this cycle is not up yet, so its whack counts for nothing.
    hits       = active ? (whack & mole_up & ~spawn) : '0;
    missed     = up_q & ~mole_up & ~hit_seen;
    score_sum  = {1'b0, score} + {5'd0, popcount8(hits)};
    score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
`ifdef MOLE_SCHED_WHIFF_PENALTY_EN
    whiffs     = active ? (whack & ~mole_up & ~spawn) : '0;
    whiff_n    = popcount8(whiffs);
    score_next = (score_next < {4'd0, whiff_n}) ? 8'd0 : score_next - {4'd0, whiff_n};
`endif
    miss_sum   = {1'b0, misses} + {1'b0, popcount8(missed)};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      up_q     <= '0;
      hit_seen <= '0;
      molehit  <= '0;
      score    <= 8'd0;
      misses   <= 4'd0;
    end else begin
      up_q     <= mole_up;
      // A hit mark lives until that mole drops, so its fall is not a miss.
      hit_seen <= (hit_seen | hits) & mole_up;
      molehit  <= hits;
      score    <= score_next;
      if (active && (misses < MISS_LIMIT))
        misses <= miss_sum[4] ? 4'hF : miss_sum[3:0];
    end
  end
endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole spawn scheduler: paces spawns by difficulty, probes for a free hole,
// and ends the game on too many misses. Option macro: MOLE_SCHED_WHIFF_PENALTY_EN.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int GAP_EASY   = 150000000,
  parameter int GAP_MED    = 100000000,
  parameter int GAP_HARD   = 50000000,
  parameter int MAX_MISSES = 8
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  mole_scheduler_if.slave   bus
);
  localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISSES);

  state_e               state;
  logic [31:0]          gap_cnt;
  logic [1:0]           diff;
  logic [2:0]           cand, mtime, probes, next_cand;
  logic                 active, go, lose;
  logic [NUM_HOLES-1:0] spawn_vec;
  logic                 unused_rnd;

  function automatic logic [31:0] gap_for(input logic [1:0] d);
    case (d)
      DIFF_EASY: return 32'(GAP_EASY);
      DIFF_MED:  return 32'(GAP_MED);
      default:   return 32'(GAP_HARD);
    endcase
  endfunction

  assign active     = (state == ST_GAP) || (state == ST_PICK) ||
                      (state == ST_PROBE) || (state == ST_SPAWN);
  assign go         = bus.start && ((state == ST_IDLE) || (state == ST_OVER));
  assign lose       = bus.misses >= MISS_LIMIT;
  assign next_cand  = cand + 3'd1;
  assign spawn_vec  = (state == ST_SPAWN) ? (8'd1 << cand) : '0;
  assign unused_rnd = &{1'b0, bus.rnd[7:6]};

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state   <= ST_IDLE;
      gap_cnt <= 32'd0;
      diff    <= DIFF_EASY;
      cand    <= 3'd0;
      mtime   <= 3'd0;
      probes  <= 3'd0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER: begin
          if (go) begin
            diff    <= bus.difficulty;
            gap_cnt <= gap_for(bus.difficulty);
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (lose)                state   <= ST_OVER;
          else if (gap_cnt == 0)   state   <= ST_PICK;
          else                     gap_cnt <= gap_cnt - 32'd1;
        end
        ST_PICK: begin
          cand   <= bus.rnd[2:0];
          mtime  <= bus.rnd[5:3];
          probes <= 3'd0;
          if (lose)                          state <= ST_OVER;
          else if (bus.mole_up[bus.rnd[2:0]]) state <= ST_PROBE;
          else                               state <= ST_SPAWN;
        end
        ST_PROBE: begin
          cand   <= next_cand;
          probes <= probes + 3'd1;
          // Seven probes cover every other hole; all full means skip this round.
          if (lose)                          state <= ST_OVER;
          else if (!bus.mole_up[next_cand])  state <= ST_SPAWN;
          else if (probes == 3'd6) begin
            gap_cnt <= gap_for(diff);
            state   <= ST_GAP;
          end
        end
        ST_SPAWN: begin
          gap_cnt <= gap_for(diff);
          state   <= lose ? ST_OVER : ST_GAP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mole_hit_tracker #(.MAX_MISSES(MAX_MISSES)) u_tracker (
    .clk     (CLK100MHZ),
    .rst     (reset),
    .clr     (go),
    .active  (active),
    .mole_up (bus.mole_up),
    .whack   (bus.whack),
    .spawn   (spawn_vec),
    .molehit (bus.molehit),
    .score   (bus.score),
    .misses  (bus.misses)
  );

  assign bus.spawn     = spawn_vec;
  assign bus.moletime  = (state == ST_SPAWN) ? mtime : 3'd0;
  assign bus.game_over = (state == ST_OVER);
  assign bus.busy      = active;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler with short gaps (20/10/5) and MAX_MISSES=2.
module tb_mole_scheduler;
  localparam int G_EASY = 20;
  localparam int G_MED  = 10;
  localparam int G_HARD = 5;
  localparam int MAXM   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_q[$];

  mole_scheduler_if bus();

  mole_scheduler #(.GAP_EASY(G_EASY), .GAP_MED(G_MED), .GAP_HARD(G_HARD), .MAX_MISSES(MAXM)) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .bus       (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.start = 1'b0; bus.whack = 8'h00; bus.difficulty = 2'b00;
    tick(); tick();
    reset = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic start_game(input logic [1:0] d);
    bus.difficulty = d; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_spawn(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (bus.spawn !== 8'h00) begin n = i; break; end
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int gap_of(input logic [1:0] d);
    return (d == 2'b00) ? G_EASY : (d == 2'b01) ? G_MED : G_HARD;
  endfunction

  // Number of extra holes stepped past before landing on a free one.
  function automatic int probe_dist(input logic [7:0] up, input logic [2:0] from);
    for (int k = 0; k < 8; k++) if (!up[(int'(from) + k) % 8]) return k;
    return -1;
  endfunction

  function automatic int next_score(input int s, input logic [7:0] w, input logic [7:0] up, input logic [7:0] sp);
    int r;
    r = s + $countones(w & up & ~sp);
    if (r > 255) r = 255;
`ifdef MOLE_SCHED_WHIFF_PENALTY_EN
    r = r - $countones(w & ~up & ~sp);
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    bus.rnd = 8'h00; bus.mole_up = 8'h01;
    start_game(2'b01);
    bus.whack = 8'h01; tick(); bus.whack = 8'h00;
    reset = 1'b1; tick();
    checks++; if (bus.spawn !== 8'h00) begin failures++; $display("FAIL reset_spawn: got %h expected 00", bus.spawn); end
    checks++; if (bus.molehit !== 8'h00) begin failures++; $display("FAIL reset_molehit: got %h expected 00", bus.molehit); end
    checks++; if (bus.moletime !== 3'd0) begin failures++; $display("FAIL reset_moletime: got %0d expected 0", bus.moletime); end
    checks++; if (bus.score !== 8'd0) begin failures++; $display("FAIL reset_score: got %0d expected 0", bus.score); end
    checks++; if (bus.misses !== 4'd0) begin failures++; $display("FAIL reset_misses: got %0d expected 0", bus.misses); end
    checks++; if (bus.game_over !== 1'b0) begin failures++; $display("FAIL reset_game_over: got %b expected 0", bus.game_over); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    reset = 1'b0;
  endtask

  task automatic test_first_spawn_and_probe();
    int n;
    do_reset();
    bus.mole_up = 8'h00; bus.rnd = 8'h2B;
    start_game(2'b01);
    wait_spawn(100, n);
    checks++; if (n != G_MED + 2) begin failures++; $display("FAIL first_latency: got %0d expected %0d", n, G_MED + 2); end
    checks++; if (bus.spawn !== 8'h08) begin failures++; $display("FAIL first_spawn: got %h expected 08", bus.spawn); end
    checks++; if (bus.moletime !== 3'b101) begin failures++; $display("FAIL first_moletime: got %b expected 101", bus.moletime); end
    tick();
    checks++; if (bus.spawn !== 8'h00) begin failures++; $display("FAIL first_pulse_width: got %h expected 00", bus.spawn); end
    // hole 3 up, pick lands on 3, one probe step to 4
    bus.mole_up = 8'h08; bus.rnd = 8'h03;
    wait_spawn(100, n);
    checks++; if (n != G_MED + 3 + 1 - 1) begin failures++; $display("FAIL probe_interval: got %0d expected %0d", n, G_MED + 3); end
    checks++; if (bus.spawn !== 8'h10) begin failures++; $display("FAIL probe_spawn: got %h expected 10", bus.spawn); end
    bus.mole_up = 8'hFF;
    wait_spawn(60, n);
    checks++; if (n != -1) begin failures++; $display("FAIL full_no_spawn: got spawn after %0d cycles expected none", n); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL full_busy: got %b expected 1", bus.busy); end
    bus.mole_up = 8'h7F;
    wait_spawn(100, n);
    checks++; if (bus.spawn !== 8'h80) begin failures++; $display("FAIL refill_spawn: got %h expected 80 after %0d", bus.spawn, n); end
    checks++; if (bus.misses !== 4'd1) begin failures++; $display("FAIL refill_misses: got %0d expected 1", bus.misses); end
  endtask

  task automatic test_random_spawn();
    int n, p;
    logic [7:0] up;
    logic [7:0] r;
    logic [1:0] d;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      up = 8'($urandom_range(0, 254));
      r  = 8'($urandom_range(0, 255));
      d  = 2'($urandom_range(0, 3));
      bus.mole_up = up; bus.rnd = r;
      start_game(d);
      p = probe_dist(up, r[2:0]);
      wait_spawn(200, n);
      checks++; if (n != gap_of(d) + 2 + p) begin failures++; $display("FAIL rand_latency: got %0d expected %0d (d=%0d up=%h r=%h)", n, gap_of(d) + 2 + p, d, up, r); end
      checks++; if (bus.spawn !== 8'(1 << ((int'(r[2:0]) + p) % 8))) begin failures++; $display("FAIL rand_hole: got %h expected hole %0d (up=%h r=%h)", bus.spawn, (int'(r[2:0]) + p) % 8, up, r); end
      checks++; if (bus.moletime !== r[5:3]) begin failures++; $display("FAIL rand_moletime: got %0d expected %0d", bus.moletime, r[5:3]); end
      tick();
      checks++; if (bus.spawn !== 8'h00) begin failures++; $display("FAIL rand_pulse_width: got %h expected 00", bus.spawn); end
    end
  endtask

  task automatic test_hit();
    int n;
    logic [7:0] s;
    do_reset();
    bus.rnd = 8'h00; bus.mole_up = 8'h00;
    start_game(2'b10);
    bus.mole_up = 8'h20; tick();
    bus.whack = 8'h20; tick(); bus.whack = 8'h00;
    checks++; if (bus.molehit !== 8'h20) begin failures++; $display("FAIL hit_molehit: got %h expected 20", bus.molehit); end
    checks++; if (bus.score !== 8'd1) begin failures++; $display("FAIL hit_score: got %0d expected 1", bus.score); end
    tick();
    checks++; if (bus.molehit !== 8'h00) begin failures++; $display("FAIL hit_pulse_width: got %h expected 00", bus.molehit); end
    bus.mole_up = 8'h00; tick(); tick();
    checks++; if (bus.misses !== 4'd0) begin failures++; $display("FAIL hit_no_miss: got %0d expected 0", bus.misses); end
    // whack landing on the hole being spawned in the same cycle
    wait_spawn(50, n);
    s = bus.score;
    bus.whack = bus.spawn; tick(); bus.whack = 8'h00;
    checks++; if (bus.molehit !== 8'h00) begin failures++; $display("FAIL spawn_whack_molehit: got %h expected 00", bus.molehit); end
    checks++; if (bus.score !== s) begin failures++; $display("FAIL spawn_whack_score: got %0d expected %0d", bus.score, s); end
  endtask

  task automatic test_random_hits();
    logic [7:0] up, w, sp, exp_hit;
    int s;
    do_reset();
    bus.rnd = 8'h00;
    up = 8'($urandom_range(1, 255));
    bus.mole_up = up;
    start_game(2'b00);
    s = 0;
    for (int i = 0; i < 40; i++) begin
      w = 8'($urandom_range(0, 255));
      sp = bus.spawn;
      bus.whack = w;
      exp_q.push_back(w & up & ~sp);
      s = next_score(s, w, up, sp);
      tick();
      exp_hit = exp_q.pop_front();
      checks++; if (bus.molehit !== exp_hit) begin failures++; $display("FAIL rhit_molehit: got %h expected %h (i=%0d)", bus.molehit, exp_hit, i); end
      checks++; if (bus.score !== 8'(s)) begin failures++; $display("FAIL rhit_score: got %0d expected %0d (i=%0d)", bus.score, s, i); end
    end
    bus.whack = 8'h00;
  endtask

  task automatic test_saturation();
    do_reset();
    bus.rnd = 8'h00; bus.mole_up = 8'hFF;
    start_game(2'b00);
    bus.whack = 8'hFF;
    repeat (32) tick();
    checks++; if (bus.score !== 8'd255) begin failures++; $display("FAIL sat_reach: got %0d expected 255", bus.score); end
    tick();
    checks++; if (bus.score !== 8'd255) begin failures++; $display("FAIL sat_hold: got %0d expected 255", bus.score); end
    checks++; if (bus.molehit !== 8'hFF) begin failures++; $display("FAIL sat_molehit: got %h expected ff", bus.molehit); end
    bus.whack = 8'h00;
  endtask

  task automatic test_whiff();
    logic [7:0] e;
    do_reset();
    bus.rnd = 8'h04; bus.mole_up = 8'h01;
    start_game(2'b00);
    bus.whack = 8'h02; tick(); bus.whack = 8'h00;
    checks++; if (bus.score !== 8'd0) begin failures++; $display("FAIL whiff_at_zero: got %0d expected 0", bus.score); end
    checks++; if (bus.molehit !== 8'h00) begin failures++; $display("FAIL whiff_molehit: got %h expected 00", bus.molehit); end
    bus.whack = 8'h01; repeat (3) tick(); bus.whack = 8'h00;
    checks++; if (bus.score !== 8'd3) begin failures++; $display("FAIL whiff_prefill: got %0d expected 3", bus.score); end
    bus.whack = 8'h02; tick(); bus.whack = 8'h00;
`ifdef MOLE_SCHED_WHIFF_PENALTY_EN
    e = 8'd2;
`else
    e = 8'd3;
`endif
    checks++; if (bus.score !== e) begin failures++; $display("FAIL whiff_at_three: got %0d expected %0d", bus.score, e); end
  endtask

  task automatic test_game_over();
    int spawns, hits;
    do_reset();
    bus.rnd = 8'h00; bus.mole_up = 8'h00;
    start_game(2'b10);
    bus.mole_up = 8'h0E; tick();
    bus.whack = 8'h08; tick(); bus.whack = 8'h00;
    bus.mole_up = 8'h0C; tick();
    checks++; if (bus.misses !== 4'd1) begin failures++; $display("FAIL over_miss1: got %0d expected 1", bus.misses); end
    bus.mole_up = 8'h08; tick();
    checks++; if (bus.misses !== 4'd2) begin failures++; $display("FAIL over_miss2: got %0d expected 2", bus.misses); end
    checks++; if (bus.game_over !== 1'b0) begin failures++; $display("FAIL over_early: got %b expected 0", bus.game_over); end
    tick();
    checks++; if (bus.game_over !== 1'b1) begin failures++; $display("FAIL over_flag: got %b expected 1", bus.game_over); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL over_busy: got %b expected 0", bus.busy); end
    spawns = 0; hits = 0;
    bus.whack = 8'h08;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.spawn !== 8'h00) spawns++;
      if (bus.molehit !== 8'h00) hits++;
    end
    bus.whack = 8'h00;
    checks++; if (spawns != 0) begin failures++; $display("FAIL over_spawn: got %0d spawns expected 0", spawns); end
    checks++; if (hits != 0) begin failures++; $display("FAIL over_molehit: got %0d pulses expected 0", hits); end
    checks++; if (bus.score !== 8'd1) begin failures++; $display("FAIL over_score_frozen: got %0d expected 1", bus.score); end
    start_game(2'b01);
    checks++; if (bus.score !== 8'd0) begin failures++; $display("FAIL restart_score: got %0d expected 0", bus.score); end
    checks++; if (bus.misses !== 4'd0) begin failures++; $display("FAIL restart_misses: got %0d expected 0", bus.misses); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL restart_busy: got %b expected 1", bus.busy); end
  endtask

  task automatic test_reset_in_spawn();
    int n;
    do_reset();
    bus.rnd = 8'h00; bus.mole_up = 8'h02;
    start_game(2'b10);
    bus.whack = 8'h02; tick(); bus.whack = 8'h00;
    wait_spawn(50, n);
    checks++; if (n == -1) begin failures++; $display("FAIL rs_spawn_seen: got no spawn expected one within 50"); end
    reset = 1'b1; bus.start = 1'b1; tick();
    checks++; if (bus.spawn !== 8'h00) begin failures++; $display("FAIL rs_spawn: got %h expected 00", bus.spawn); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rs_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.score !== 8'd0) begin failures++; $display("FAIL rs_score: got %0d expected 0", bus.score); end
    checks++; if (bus.misses !== 4'd0) begin failures++; $display("FAIL rs_misses: got %0d expected 0", bus.misses); end
    checks++; if (bus.moletime !== 3'd0) begin failures++; $display("FAIL rs_moletime: got %0d expected 0", bus.moletime); end
    reset = 1'b0; bus.start = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.start = 1'b0; bus.difficulty = 2'b00; bus.rnd = 8'h00;
    bus.mole_up = 8'h00; bus.whack = 8'h00;
    test_reset();
    test_first_spawn_and_probe();
    test_random_spawn();
    test_hit();
    test_random_hits();
    test_saturation();
    test_whiff();
    test_game_over();
    test_reset_in_spawn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  GAP_EASY, 150000000, idle cycles between spawns at difficulty 2'b00
  GAP_MED, 100000000, idle cycles between spawns at difficulty 2'b01
  GAP_HARD, 50000000, idle cycles between spawns at difficulty 2'b10/2'b11
  MAX_MISSES, 8, miss count that ends the game (1..15)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  CLK100MHZ  in  1  sole clock; all logic on rising edge
  reset  in  1  synchronous, active-high reset
  start  in  1  level; start a game from IDLE or OVER
  difficulty  in  2  sampled at start, held for the game
  rnd  in  8  free-running LFSR value; [2:0] = hole, [5:3] = moletime
  mole_up  in  8  omole of the eight mole timers
  whack  in  8  debounced single-cycle button pulses, one per hole
  spawn  out  8  one-hot single-cycle pulse to the selected timer's mole/enable
  moletime  out  3  time code for the timer, valid with spawn
  molehit  out  8  single-cycle pulse to the timer being hit
  score  out  8  hit count, saturating at 255
  misses  out  4  missed-mole count
  game_over  out  1  high in OVER
  busy  out  1  high in GAP, PICK, PROBE, SPAWN

Function
REQ-003 FSM states SHALL be IDLE, GAP, PICK, PROBE, SPAWN, OVER.
REQ-004 IDLE: on start=1, latch difficulty, clear score/misses, load gap counter, go to GAP.
REQ-005 GAP: decrement the gap counter each cycle; at 0 go to PICK; the gap counter SHALL NOT reload while a spawn is pending.
REQ-006 PICK: latch cand=rnd[2:0] and time=rnd[5:3]; if mole_up[cand]=0 go to SPAWN, else go to PROBE.
REQ-007 PROBE: cand=(cand+1) mod 8 per cycle (3-bit wrap 7->0); go to SPAWN at first free hole; after 7 probes with no free hole, go to GAP with counter reloaded and no spawn.
REQ-008 SPAWN: drive spawn[cand]=1 and moletime=time for exactly one cycle, reload gap counter, go to GAP.
REQ-009 Hit: whack[i]=1 and mole_up[i]=1 in any non-IDLE/non-OVER state SHALL pulse molehit[i] the next cycle and increment score (saturating at 255).
REQ-010 Miss: a registered 1->0 transition of mole_up[i] with no molehit[i] issued for that mole SHALL increment misses.
REQ-011 Simultaneous hits on several holes SHALL each pulse molehit and add the popcount to score in one cycle, saturating.
REQ-012 When misses reaches MAX_MISSES, enter OVER the next cycle; no spawn, molehit or score change in OVER; miss counting stops.
REQ-013 OVER: on start=1, behave as IDLE start (REQ-004).
REQ-014 A spawn and a whack on the same hole in the same cycle: the whack is ignored (mole not yet up).

Reset
REQ-015 reset=1 SHALL, on the next edge, force IDLE, spawn=0, molehit=0, moletime=0, score=0, misses=0, game_over=0, busy=0, clear the edge-detect registers and the gap counter; reset SHALL override start.

Configuration
REQ-016 With MOLE_SCHED_WHIFF_PENALTY_EN defined, a whack on a hole with mole_up=0 SHALL decrement score, saturating at 0, and is applied after same-cycle hits. Without it, such whacks are ignored.

Structure
REQ-017 Package mole_pkg SHALL hold the FSM state enum, the difficulty codes and NUM_HOLES=8.
REQ-018 One sub-module, mole_hit_tracker (hit/miss detection, molehit generation, score/miss counters), SHALL be instantiated; the FSM stays in mole_scheduler.

Verification (GAP_EASY/MED/HARD=20/10/5, MAX_MISSES=2)
REQ-019 reset, start=1, difficulty=01, rnd=8'h2B -> spawn=8'h08 with moletime=3'b101 exactly 12 cycles after start; one-cycle pulse.
REQ-020 mole_up=8'h08, rnd[2:0]=3 at PICK -> PROBE selects hole 4, spawn=8'h10; mole_up=8'hFF -> no spawn, return to GAP.
REQ-021 mole_up[5]=1, whack=8'h20 -> molehit=8'h20 next cycle, score 0->1; mole_up[5] falling afterwards -> misses unchanged.
REQ-022 Two moles fall unhit -> misses=2, game_over=1, busy=0, no further spawn; start=1 -> score=0, misses=0, GAP.
REQ-023 score=255 plus hit -> stays 255; with MOLE_SCHED_WHIFF_PENALTY_EN, whack on empty hole at score=0 -> stays 0, at score=3 -> 2.
REQ-024 reset asserted in SPAWN together with start=1 -> next cycle spawn=0, IDLE, all counters 0.
